// File: rtl/wino_pkg.sv
// Shared constants, tile types and controller state encoding for the Winograd-domain accumulator.
package wino_pkg;

  localparam int unsigned TILE  = 6;
  localparam int unsigned RES_W = 12;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned IDX_W = 9;
  localparam int unsigned OD_W  = 8;
  localparam int unsigned IC_W  = 8;

  typedef logic signed [RES_W-1:0] res_tile_t [TILE][TILE];
  typedef logic signed [ACC_W-1:0] acc_tile_t [TILE][TILE];

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } accum_state_e;

endpackage

// File: rtl/wino_acc_elem.sv
// One accumulator element: load or add a sign-extended product.
// Define WINO_ACC_SAT_EN to saturate the add instead of wrapping.
module wino_acc_elem
  import wino_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic                    add_i,
  input  logic signed [RES_W-1:0] din_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] add_res;

  assign din_ext = {{(ACC_W-RES_W){din_i[RES_W-1]}}, din_i};

`ifdef WINO_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_wide;

  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {din_ext[ACC_W-1], din_ext};
    // The two top bits disagree only when the signed add left the ACC_W range.
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      add_res = sum_wide[ACC_W] ? AccMin : AccMax;
    end else begin
      add_res = sum_wide[ACC_W-1:0];
    end
  end
`else
  assign add_res = acc_q + din_ext;
`endif

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = din_ext;
    end else if (add_i) begin
      acc_d = add_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/winograd_accum.sv
// Sums num_ic consecutive same-key PE product tiles and hands each sum out through one
// valid/ready output register. Never back-pressures; WINO_ACC_SAT_EN selects saturating adds.
module winograd_accum
  import wino_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  res_tile_t        result_tile_i,
  input  logic [OD_W-1:0]  result_od_i,
  input  logic [IDX_W-1:0] result_x_index_i,
  input  logic [IDX_W-1:0] result_y_index_i,
  input  logic             result_valid_i,
  input  logic [IC_W-1:0]  num_ic_i,
  output acc_tile_t        acc_tile_o,
  output logic [OD_W-1:0]  acc_od_o,
  output logic [IDX_W-1:0] acc_x_index_o,
  output logic [IDX_W-1:0] acc_y_index_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             busy_o,
  output logic             key_err_o,
  output logic             overrun_o
);

  accum_state_e     state_q, state_d;
  logic [IC_W-1:0]  count_q, count_d;
  logic [IC_W-1:0]  num_ic_q, num_ic_d;
  logic [IC_W-1:0]  num_ic_eff;
  logic [OD_W-1:0]  od_q, od_d;
  logic [IDX_W-1:0] x_q, x_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             key_err_q, key_err_d;
  logic             overrun_q, overrun_d;
  logic             load, add, xfer, key_match;

  acc_tile_t        acc_val;
  acc_tile_t        out_tile_q;
  logic [OD_W-1:0]  out_od_q;
  logic [IDX_W-1:0] out_x_q;
  logic [IDX_W-1:0] out_y_q;

  assign num_ic_eff = (num_ic_i == '0) ? IC_W'(1) : num_ic_i;
  assign key_match  = (result_od_i == od_q) && (result_x_index_i == x_q) &&
                      (result_y_index_i == y_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    num_ic_d  = num_ic_q;
    od_d      = od_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = valid_q;
    key_err_d = key_err_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    add       = 1'b0;
    xfer      = 1'b0;

    if (valid_q && acc_ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (result_valid_i) begin
          load     = 1'b1;
          od_d     = result_od_i;
          x_d      = result_x_index_i;
          y_d      = result_y_index_i;
          num_ic_d = num_ic_eff;
          count_d  = IC_W'(1);
          state_d  = (num_ic_eff == IC_W'(1)) ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (result_valid_i) begin
          if (key_match) begin
            add     = 1'b1;
            count_d = count_q + 1'b1;
            if (count_d == num_ic_q) begin
              state_d = StHold;
            end
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      StHold: begin
        // Refill in the same cycle the old output is taken, so valid never bubbles.
        if (!valid_q || acc_ready_i) begin
          xfer    = 1'b1;
          valid_d = 1'b1;
          state_d = StIdle;
        end
        if (result_valid_i) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      num_ic_q  <= '0;
      od_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      key_err_q <= 1'b0;
      overrun_q <= 1'b0;
      out_od_q  <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      num_ic_q  <= num_ic_d;
      od_q      <= od_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      key_err_q <= key_err_d;
      overrun_q <= overrun_d;
      if (xfer) begin
        out_od_q <= od_q;
        out_x_q  <= x_q;
        out_y_q  <= y_q;
      end
    end
  end

  for (genvar r = 0; r < TILE; r++) begin : g_row
    for (genvar c = 0; c < TILE; c++) begin : g_col
      wino_acc_elem u_elem (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .add_i  (add),
        .din_i  (result_tile_i[r][c]),
        .acc_o  (acc_val[r][c])
      );

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_tile_q[r][c] <= '0;
        end else if (xfer) begin
          out_tile_q[r][c] <= acc_val[r][c];
        end
      end
    end
  end

  assign acc_tile_o    = out_tile_q;
  assign acc_od_o      = out_od_q;
  assign acc_x_index_o = out_x_q;
  assign acc_y_index_o = out_y_q;
  assign acc_valid_o   = valid_q;
  assign busy_o        = (state_q != StIdle);
  assign key_err_o     = key_err_q;
  assign overrun_o     = overrun_q;

endmodule
